// File: rtl/wt_mem_port_arbiter.sv
// N-client memory-side arbiter: round-robin issue, per-client outstanding tracking, return routing by ID, invalidation broadcast.
// Latency: accepted request appears on mem_req_* next cycle; returns route combinationally; invalidation pulse one cycle after accept.
// Backpressure: mem_req_* held while !mem_req_ready_i; clients blocked at MaxOutstanding; invalidations stalled while a return is valid.
// Optional: define WT_ARB_PERF_CNT_EN to add perf_stall_o (per-client 16-bit saturating stall counters).
module wt_mem_port_arbiter #(
  parameter int NumPorts       = 2,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int TxIdWidth      = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumPorts-1:0]                    req_valid_i,
  output logic [NumPorts-1:0]                    req_ready_o,
  input  logic [NumPorts-1:0]                    req_write_i,
  input  logic [NumPorts*AddrWidth-1:0]          req_addr_i,
  input  logic [NumPorts*DataWidth-1:0]          req_data_i,
  input  logic [NumPorts*TxIdWidth-1:0]          req_txid_i,
  output logic                                   mem_req_valid_o,
  input  logic                                   mem_req_ready_i,
  output logic                                   mem_req_write_o,
  output logic [AddrWidth-1:0]                   mem_req_addr_o,
  output logic [DataWidth-1:0]                   mem_req_data_o,
  output logic [$clog2(NumPorts)+TxIdWidth-1:0]  mem_req_id_o,
  input  logic                                   mem_rtrn_valid_i,
  input  logic [$clog2(NumPorts)+TxIdWidth-1:0]  mem_rtrn_id_i,
  input  logic [DataWidth-1:0]                   mem_rtrn_data_i,
  output logic [NumPorts-1:0]                    rtrn_valid_o,
  output logic [TxIdWidth-1:0]                   rtrn_txid_o,
  output logic [DataWidth-1:0]                   rtrn_data_o,
  input  logic                                   inval_valid_i,
  input  logic [AddrWidth-1:0]                   inval_addr_i,
  output logic                                   inval_ready_o,
  output logic [NumPorts-1:0]                    inval_valid_o,
  output logic [AddrWidth-1:0]                   inval_addr_o,
  output logic                                   idle_o,
  output logic                                   err_o
`ifdef WT_ARB_PERF_CNT_EN
  ,
  output logic [NumPorts*16-1:0]                 perf_stall_o
`endif
);

  localparam int PortW = $clog2(NumPorts);
  localparam int CntW  = TxIdWidth + 1;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PortW-1:0]    rr_q;
  logic [PortW-1:0]    grant;
  logic                grant_found;
  logic                load;
  logic [NumPorts-1:0] eligible;
  logic [CntW-1:0]     cnt_q [NumPorts];
  logic [PortW-1:0]    ret_port;
  logic                all_zero;
  logic                inval_pulse_q;

  // Eligibility: client requesting and below its outstanding limit
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = req_valid_i[p] && (cnt_q[p] < CntW'(MaxOutstanding));
    end
  end

  // Round-robin search: first eligible client at or after the pointer
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!grant_found && eligible[(int'(rr_q) + i) % NumPorts]) begin
        grant_found = 1'b1;
        grant       = PortW'((int'(rr_q) + i) % NumPorts);
      end
    end
  end

  // Output-register FSM next state; a load can happen when empty or when the held request drains
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: load = grant_found;
      ST_FULL:  load = grant_found && mem_req_ready_i;
      default:  load = 1'b0;
    endcase
    if (rst_i) load = 1'b0;
    if (load) begin
      state_d = ST_FULL;
    end else if (state_q == ST_FULL && mem_req_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  // Per-client ready strobe is the grant of this cycle's load
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      req_ready_o[p] = load && (grant == PortW'(p));
    end
  end

  // FSM state and round-robin pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rr_q <= (int'(grant) == NumPorts - 1) ? '0 : grant + PortW'(1);
      end
    end
  end

  assign mem_req_valid_o = (state_q == ST_FULL);

  // Memory request payload register, loaded with the granted client's request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_write_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_data_o  <= '0;
      mem_req_id_o    <= '0;
    end else if (load) begin
      mem_req_write_o <= req_write_i[grant];
      mem_req_addr_o  <= req_addr_i[grant*AddrWidth +: AddrWidth];
      mem_req_data_o  <= req_data_i[grant*DataWidth +: DataWidth];
      mem_req_id_o    <= {grant, req_txid_i[grant*TxIdWidth +: TxIdWidth]};
    end
  end

  // Return routing: strobe only a client that actually has a transaction outstanding
  assign ret_port    = mem_rtrn_id_i[PortW+TxIdWidth-1:TxIdWidth];
  assign rtrn_txid_o = mem_rtrn_id_i[TxIdWidth-1:0];
  assign rtrn_data_o = mem_rtrn_data_i;
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rtrn_valid_o[p] = mem_rtrn_valid_i && (ret_port == PortW'(p)) && (cnt_q[p] != '0);
    end
  end

  // Outstanding counters: +1 on load, -1 on accepted return, unchanged when both coincide
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++) cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (req_ready_o[p] && !rtrn_valid_o[p]) begin
          cnt_q[p] <= cnt_q[p] + CntW'(1);
        end else if (rtrn_valid_o[p] && !req_ready_o[p]) begin
          cnt_q[p] <= cnt_q[p] - CntW'(1);
        end
      end
    end
  end

  // Sticky error on a return that no client was waiting for (including out-of-range port field)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (mem_rtrn_valid_i && (rtrn_valid_o == '0)) begin
      err_o <= 1'b1;
    end
  end

  // Idle when nothing is outstanding and the output register is empty
  always_comb begin
    all_zero = 1'b1;
    for (int p = 0; p < NumPorts; p++) begin
      if (cnt_q[p] != '0) all_zero = 1'b0;
    end
  end
  assign idle_o = all_zero && (state_q == ST_EMPTY);

  // Returns take priority over invalidations since returns cannot be stalled
  assign inval_ready_o = !rst_i && !mem_rtrn_valid_i;
  assign inval_valid_o = {NumPorts{inval_pulse_q}};

  // Invalidation broadcast: one-cycle pulse with registered address after each accept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inval_pulse_q <= 1'b0;
      inval_addr_o  <= '0;
    end else begin
      inval_pulse_q <= inval_valid_i && inval_ready_o;
      if (inval_valid_i && inval_ready_o) inval_addr_o <= inval_addr_i;
    end
  end

`ifdef WT_ARB_PERF_CNT_EN
  logic [15:0] stall_q [NumPorts];

  // Saturating stall counters: client valid but not granted this cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++) stall_q[p] <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (req_valid_i[p] && !req_ready_o[p] && (stall_q[p] != 16'hFFFF)) begin
          stall_q[p] <= stall_q[p] + 16'd1;
        end
      end
    end
  end

  // Flatten stall counters onto the output bus
  always_comb begin
    for (int p = 0; p < NumPorts; p++) perf_stall_o[p*16 +: 16] = stall_q[p];
  end
`endif

endmodule

// File: tb/tb_wt_mem_port_arbiter.sv
// Directed self-checking bench for wt_mem_port_arbiter (NumPorts=2, TxIdWidth=2, MaxOutstanding=4).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each task resets the DUT, drives one scenario and compares against hand-computed values.
module tb_wt_mem_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 2;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    req_valid = '0;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    req_write = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_data = '0;
  logic [NP*TW-1:0] req_txid = '0;
  logic             mem_req_valid;
  logic             mem_req_ready = 1'b0;
  logic             mem_req_write;
  logic [AW-1:0]    mem_req_addr;
  logic [DW-1:0]    mem_req_data;
  logic [IW-1:0]    mem_req_id;
  logic             mem_rtrn_valid = 1'b0;
  logic [IW-1:0]    mem_rtrn_id = '0;
  logic [DW-1:0]    mem_rtrn_data = '0;
  logic [NP-1:0]    rtrn_valid;
  logic [TW-1:0]    rtrn_txid;
  logic [DW-1:0]    rtrn_data;
  logic             inval_valid = 1'b0;
  logic [AW-1:0]    inval_addr = '0;
  logic             inval_ready;
  logic [NP-1:0]    inval_valid_out;
  logic [AW-1:0]    inval_addr_out;
  logic             idle;
  logic             err;

  int checks = 0;
  int errors = 0;

  wt_mem_port_arbiter #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TxIdWidth(TW), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_txid_i(req_txid),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_write_o(mem_req_write), .mem_req_addr_o(mem_req_addr),
    .mem_req_data_o(mem_req_data), .mem_req_id_o(mem_req_id),
    .mem_rtrn_valid_i(mem_rtrn_valid), .mem_rtrn_id_i(mem_rtrn_id), .mem_rtrn_data_i(mem_rtrn_data),
    .rtrn_valid_o(rtrn_valid), .rtrn_txid_o(rtrn_txid), .rtrn_data_o(rtrn_data),
    .inval_valid_i(inval_valid), .inval_addr_i(inval_addr), .inval_ready_o(inval_ready),
    .inval_valid_o(inval_valid_out), .inval_addr_o(inval_addr_out),
    .idle_o(idle), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid      = '0;
    req_write      = '0;
    req_txid       = '0;
    mem_req_ready  = 1'b0;
    mem_rtrn_valid = 1'b0;
    mem_rtrn_id    = '0;
    mem_rtrn_data  = '0;
    inval_valid    = 1'b0;
    inval_addr     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b exp 0", mem_req_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
    checks++; if (inval_ready !== 1'b0) begin errors++; $display("FAIL rst_inval_ready got %b exp 0", inval_ready); end
    checks++; if (inval_valid_out !== 2'b00) begin errors++; $display("FAIL rst_inval_valid got %b exp 00", inval_valid_out); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    checks++; if (mem_req_addr !== 64'h0 || mem_req_id !== 3'b000) begin errors++; $display("FAIL rst_mem_payload got %h/%b exp 0/000", mem_req_addr, mem_req_id); end
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [2:0]  exp_id;
    logic [63:0] exp_addr;
    do_reset();
    req_addr      = {64'h0000_1100, 64'h0000_1000};
    req_data      = {64'hD1, 64'hD0};
    req_txid      = {2'd1, 2'd0};
    mem_req_ready = 1'b1;
    req_valid     = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
      if (k == 0) begin
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rr_first_valid got %b exp 0", mem_req_valid); end
      end else begin
        exp_id   = ((k - 1) % 2 == 0) ? 3'b000 : 3'b101;
        exp_addr = ((k - 1) % 2 == 0) ? 64'h1000 : 64'h1100;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_id !== exp_id || mem_req_addr !== exp_addr)
          begin errors++; $display("FAIL rr_issue[%0d] got v=%b id=%b a=%h exp 1/%b/%h", k, mem_req_valid, mem_req_id, mem_req_addr, exp_id, exp_addr); end
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  task automatic test_outstanding();
    do_reset();
    req_addr      = {64'h0000_2100, 64'h0000_2000};
    mem_req_ready = 1'b1;
    req_valid     = 2'b01;
    for (int k = 0; k < 4; k++) begin
      req_txid[1:0] = TW'(k);
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL out_load[%0d] got %b exp 01", k, req_ready); end
      next_cycle();
    end
    req_valid = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL out_5th_p1_served got %b exp 10", req_ready); end
    next_cycle();
    req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL out_p0_blocked got %b exp 00", req_ready); end
    next_cycle();
    mem_rtrn_valid = 1'b1;
    mem_rtrn_id    = 3'b010;
    mem_rtrn_data  = 64'hCAFE;
    @(negedge clk);
    checks++; if (rtrn_valid !== 2'b01 || rtrn_txid !== 2'd2 || rtrn_data !== 64'hCAFE)
      begin errors++; $display("FAIL out_rtrn got %b/%0d/%h exp 01/2/cafe", rtrn_valid, rtrn_txid, rtrn_data); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL out_rtrn_cycle_ready got %b exp 00", req_ready); end
    next_cycle();
    mem_rtrn_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL out_regrant got %b exp 01", req_ready); end
    next_cycle();
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_addr      = {64'h0000_3100, 64'h0000_3000};
    req_data      = {64'hB1, 64'hB0};
    req_txid      = {2'd2, 2'd1};
    req_write     = 2'b01;
    mem_req_ready = 1'b0;
    req_valid     = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_load got %b exp 01", req_ready); end
    next_cycle();
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h3000 || mem_req_data !== 64'hB0 || mem_req_id !== 3'b001 || mem_req_write !== 1'b1)
        begin errors++; $display("FAIL bp_hold[%0d] got v=%b a=%h d=%h id=%b w=%b", k, mem_req_valid, mem_req_addr, mem_req_data, mem_req_id, mem_req_write); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall[%0d] got %b exp 00", k, req_ready); end
      next_cycle();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10 || mem_req_addr !== 64'h3000) begin errors++; $display("FAIL bp_release got %b/%h exp 10/3000", req_ready, mem_req_addr); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h3100 || mem_req_id !== 3'b110 || mem_req_write !== 1'b0)
      begin errors++; $display("FAIL bp_second got v=%b a=%h id=%b w=%b exp 1/3100/110/0", mem_req_valid, mem_req_addr, mem_req_id, mem_req_write); end
    next_cycle();
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", mem_req_valid); end
    next_cycle();
    req_write = '0;
  endtask

  task automatic test_simultaneous_and_err();
    do_reset();
    mem_req_ready = 1'b1;
    req_addr      = {64'h0000_4100, 64'h0000_4000};
    req_valid     = 2'b10;
    next_cycle();
    next_cycle();
    mem_rtrn_valid = 1'b1;
    mem_rtrn_id    = 3'b111;
    @(negedge clk);
    checks++; if (rtrn_valid !== 2'b10 || rtrn_txid !== 2'd3) begin errors++; $display("FAIL sim_rtrn got %b/%0d exp 10/3", rtrn_valid, rtrn_txid); end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sim_load got %b exp 10", req_ready); end
    next_cycle();
    req_valid   = '0;
    mem_rtrn_id = 3'b101;
    @(negedge clk);
    checks++; if (rtrn_valid !== 2'b10 || idle !== 1'b0) begin errors++; $display("FAIL sim_rtrn2 got %b idle=%b exp 10/0", rtrn_valid, idle); end
    next_cycle();
    mem_rtrn_id = 3'b100;
    @(negedge clk);
    checks++; if (rtrn_valid !== 2'b10 || idle !== 1'b0) begin errors++; $display("FAIL sim_rtrn3 got %b idle=%b exp 10/0", rtrn_valid, idle); end
    next_cycle();
    mem_rtrn_valid = 1'b0;
    @(negedge clk);
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL sim_idle got idle=%b err=%b exp 1/0", idle, err); end
    next_cycle();
    mem_rtrn_valid = 1'b1;
    mem_rtrn_id    = 3'b100;
    @(negedge clk);
    checks++; if (rtrn_valid !== 2'b00) begin errors++; $display("FAIL err_suppress got %b exp 00", rtrn_valid); end
    next_cycle();
    mem_rtrn_valid = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (err !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL err_sticky got err=%b idle=%b exp 1/1", err, idle); end
    do_reset();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err); end
  endtask

  task automatic test_inval();
    do_reset();
    mem_req_ready = 1'b1;
    req_valid     = 2'b01;
    next_cycle();
    req_valid      = '0;
    mem_rtrn_valid = 1'b1;
    mem_rtrn_id    = 3'b000;
    inval_valid    = 1'b1;
    inval_addr     = 64'h8000_0040;
    @(negedge clk);
    checks++; if (inval_ready !== 1'b0 || rtrn_valid !== 2'b01) begin errors++; $display("FAIL inv_blocked got rdy=%b rv=%b exp 0/01", inval_ready, rtrn_valid); end
    next_cycle();
    mem_rtrn_valid = 1'b0;
    @(negedge clk);
    checks++; if (inval_ready !== 1'b1 || inval_valid_out !== 2'b00) begin errors++; $display("FAIL inv_accept got rdy=%b v=%b exp 1/00", inval_ready, inval_valid_out); end
    next_cycle();
    inval_valid = 1'b0;
    @(negedge clk);
    checks++; if (inval_valid_out !== 2'b11 || inval_addr_out !== 64'h8000_0040) begin errors++; $display("FAIL inv_pulse got %b/%h exp 11/80000040", inval_valid_out, inval_addr_out); end
    next_cycle();
    @(negedge clk);
    checks++; if (inval_valid_out !== 2'b00) begin errors++; $display("FAIL inv_single got %b exp 00", inval_valid_out); end
    next_cycle();
    inval_valid = 1'b1;
    inval_addr  = 64'h8000_0080;
    next_cycle();
    inval_addr  = 64'h8000_00C0;
    @(negedge clk);
    checks++; if (inval_valid_out !== 2'b11 || inval_addr_out !== 64'h8000_0080) begin errors++; $display("FAIL inv_b2b_1 got %b/%h exp 11/80000080", inval_valid_out, inval_addr_out); end
    next_cycle();
    inval_valid = 1'b0;
    @(negedge clk);
    checks++; if (inval_valid_out !== 2'b11 || inval_addr_out !== 64'h8000_00C0) begin errors++; $display("FAIL inv_b2b_2 got %b/%h exp 11/800000c0", inval_valid_out, inval_addr_out); end
    next_cycle();
    @(negedge clk);
    checks++; if (inval_valid_out !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL inv_end got %b err=%b exp 00/0", inval_valid_out, err); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_outstanding();
    test_backpressure();
    test_simultaneous_and_err();
    test_inval();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
